// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : i2c_cmd_sequencer
// Purpose  : Command front-end for an I2C master. Queues register read/write
//            commands from the host and issues them one at a time on the
//            master's go/done handshake. Returns read data on a single-entry
//            response port and guards every transaction with a timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_cmd_*/o_cmd_ready  host command push port {rw, slave, reg, wr_data}
//   o_rsp_*/i_rsp_ready  read response port (data + timeout error flag)
//   o_i2c_go, o_rw, o_i2c_slave_addr, o_reg_addr, o_wr_data, o_cycle
//                        request side towards the I2C master
//   i_i2c_done, i_reg_data
//                        completion and read data from the I2C master
//   o_busy               transaction in progress or commands queued
//   o_timeout            sticky timeout flag, cleared by i_clr_timeout
//   o_level              command FIFO occupancy
//==============================================================================
module i2c_cmd_sequencer #(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  CYCLE_DIV = 8'd50,
    parameter int          GAP       = 2,
    parameter logic [15:0] TIMEOUT   = 16'd20000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_rw,
    input  logic [6:0]                 i_cmd_slave_addr,
    input  logic [7:0]                 i_cmd_reg_addr,
    input  logic [7:0]                 i_cmd_wr_data,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [7:0]                 o_rsp_data,
    output logic                       o_rsp_err,
    output logic                       o_i2c_go,
    output logic                       o_rw,
    output logic [6:0]                 o_i2c_slave_addr,
    output logic [7:0]                 o_reg_addr,
    output logic [7:0]                 o_wr_data,
    output logic [7:0]                 o_cycle,
    input  logic                       i_i2c_done,
    input  logic [7:0]                 i_reg_data,
    output logic                       o_busy,
    output logic                       o_timeout,
    input  logic                       i_clr_timeout,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_LW-1:0] c_FULL     = c_LW'(DEPTH);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Command FIFO storage, entry = {rw, slave[6:0], reg[7:0], data[7:0]}
    logic [23:0]       r_mem_q [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [c_LW-1:0]   r_level_q,  w_level_d;

    state_t            r_state_q,  w_state_d;
    logic [15:0]       r_timer_q,  w_timer_d;
    logic [c_GW-1:0]   r_gap_q,    w_gap_d;

    logic              r_go_q,     w_go_d;
    logic              r_rw_q,     w_rw_d;
    logic [6:0]        r_slave_q,  w_slave_d;
    logic [7:0]        r_reg_q,    w_reg_d;
    logic [7:0]        r_wdata_q,  w_wdata_d;

    logic              r_rsp_valid_q, w_rsp_valid_d;
    logic [7:0]        r_rsp_data_q,  w_rsp_data_d;
    logic              r_rsp_err_q,   w_rsp_err_d;
    logic              r_timeout_q,   w_timeout_d;

    logic              w_push;
    logic              w_pop;
    logic              w_set_timeout;
    logic [23:0]       w_head;

    assign w_head      = r_mem_q[r_rd_ptr_q];
    // Ready depends only on the registered level; a pop in the same cycle
    // does not open a slot for a push while full.
    assign o_cmd_ready = (r_level_q != c_FULL);
    assign w_push      = i_cmd_valid && o_cmd_ready;

    // FIFO storage has no reset; occupancy is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= {i_cmd_rw, i_cmd_slave_addr, i_cmd_reg_addr, i_cmd_wr_data};
        end
    end

    // Next-state and output-register logic
    always_comb begin
        w_state_d     = r_state_q;
        w_timer_d     = r_timer_q;
        w_gap_d       = r_gap_q;
        w_go_d        = r_go_q;
        w_rw_d        = r_rw_q;
        w_slave_d     = r_slave_q;
        w_reg_d       = r_reg_q;
        w_wdata_d     = r_wdata_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_data_d  = r_rsp_data_q;
        w_rsp_err_d   = r_rsp_err_q;
        w_pop         = 1'b0;
        w_set_timeout = 1'b0;

        // Host handshake retires the response; a completing read below can
        // only occur while the register is empty, so ordering is harmless.
        if (r_rsp_valid_q && i_rsp_ready) begin
            w_rsp_valid_d = 1'b0;
        end

        case (r_state_q)
            S_IDLE: begin
                // A read waits at the head while an unconsumed response is
                // pending, so its data can never overwrite the old one.
                if ((r_level_q != '0) && !(w_head[23] && r_rsp_valid_q)) begin
                    w_pop     = 1'b1;
                    w_rw_d    = w_head[23];
                    w_slave_d = w_head[22:16];
                    w_reg_d   = w_head[15:8];
                    w_wdata_d = w_head[7:0];
                    w_go_d    = 1'b1;
                    w_timer_d = 16'd0;
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                w_timer_d = r_timer_q + 16'd1;
                if (i_i2c_done) begin
                    w_go_d    = 1'b0;
                    w_gap_d   = '0;
                    w_state_d = S_GAP;
                    if (r_rw_q) begin
                        w_rsp_valid_d = 1'b1;
                        w_rsp_data_d  = i_reg_data;
                        w_rsp_err_d   = 1'b0;
                    end
                end else if (r_timer_q == (TIMEOUT - 16'd1)) begin
                    w_go_d        = 1'b0;
                    w_set_timeout = 1'b1;
                    w_gap_d       = '0;
                    w_state_d     = S_GAP;
                    if (r_rw_q) begin
                        w_rsp_valid_d = 1'b1;
                        w_rsp_data_d  = 8'h00;
                        w_rsp_err_d   = 1'b1;
                    end
                end
            end
            S_GAP: begin
                // Keeps go low long enough for the master to see a fresh edge.
                if (r_gap_q == c_GAP_LAST) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_gap_d = r_gap_q + c_GW'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_go_d    = 1'b0;
            end
        endcase

        // Sticky flag: a new timeout wins over a simultaneous clear.
        if (w_set_timeout) begin
            w_timeout_d = 1'b1;
        end else if (i_clr_timeout) begin
            w_timeout_d = 1'b0;
        end else begin
            w_timeout_d = r_timeout_q;
        end
    end

    // FIFO pointer/level update (pointers wrap naturally, DEPTH is 2^n)
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level_q + c_LW'(1);
            2'b01:   w_level_d = r_level_q - c_LW'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= S_IDLE;
            r_timer_q     <= 16'd0;
            r_gap_q       <= '0;
            r_go_q        <= 1'b0;
            r_rw_q        <= 1'b0;
            r_slave_q     <= 7'd0;
            r_reg_q       <= 8'd0;
            r_wdata_q     <= 8'd0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_data_q  <= 8'd0;
            r_rsp_err_q   <= 1'b0;
            r_timeout_q   <= 1'b0;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_level_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_timer_q     <= w_timer_d;
            r_gap_q       <= w_gap_d;
            r_go_q        <= w_go_d;
            r_rw_q        <= w_rw_d;
            r_slave_q     <= w_slave_d;
            r_reg_q       <= w_reg_d;
            r_wdata_q     <= w_wdata_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_data_q  <= w_rsp_data_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_timeout_q   <= w_timeout_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_level_q     <= w_level_d;
        end
    end

    assign o_i2c_go         = r_go_q;
    assign o_rw             = r_rw_q;
    assign o_i2c_slave_addr = r_slave_q;
    assign o_reg_addr       = r_reg_q;
    assign o_wr_data        = r_wdata_q;
    assign o_cycle          = CYCLE_DIV;
    assign o_rsp_valid      = r_rsp_valid_q;
    assign o_rsp_data       = r_rsp_data_q;
    assign o_rsp_err        = r_rsp_err_q;
    assign o_timeout        = r_timeout_q;
    assign o_level          = r_level_q;
    assign o_busy           = (r_state_q != S_IDLE) || (r_level_q != '0);

endmodule
`default_nettype wire
